// File: rtl/conv_result_gather_if.sv
// conv_result_gather_if: handshake bundle between a result producer, the gather block and the downstream layer.
// Parameters: DATA_WIDTH (bits per result word), N (results per output vector).
// Signals:
//   in_data/in_valid/in_ready   scalar result stream into the gather block
//   flush                       close a partially filled vector (remaining slots zeroed)
//   out_vector/out_valid/out_ready  packed vector to downstream, element k at out_vector[DATA_WIDTH*k +: DATA_WIDTH]
//   fill_count                  number of slots currently filled
// Modports: master = producer/consumer side, slave = gather block.
interface conv_result_gather_if #(
   parameter int DATA_WIDTH = 32,
   parameter int N = 4
);
   localparam int CW = $clog2(N + 1);
   logic [DATA_WIDTH-1:0] in_data;
   logic in_valid;
   logic in_ready;
   logic flush;
   logic [0:N*DATA_WIDTH-1] out_vector;
   logic out_valid;
   logic out_ready;
   logic [CW-1:0] fill_count;
   modport master (output in_data, in_valid, flush, out_ready,
                   input in_ready, out_vector, out_valid, fill_count);
   modport slave (input in_data, in_valid, flush, out_ready,
                  output in_ready, out_vector, out_valid, fill_count);
endinterface

// File: rtl/conv_result_gather.sv
// conv_result_gather: packs N consecutive scalar results into one output-row vector with valid/ready handshakes.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    conv_result_gather_if.slave (in_data/in_valid/in_ready, flush, out_vector/out_valid/out_ready, fill_count)
// Optional: define CONV_RESULT_GATHER_RELU_EN to store negative words (sign bit set, including -0) as zero.
module conv_result_gather #(
   parameter int DATA_WIDTH = 32,
   parameter int N = 4
) (
   input logic clk,
   input logic reset,
   conv_result_gather_if.slave bus
);
   localparam int CW = $clog2(N + 1);
   typedef enum logic {COLLECT, FULL} state_t;
   state_t state;
   logic [DATA_WIDTH-1:0] slot [N];
   logic [CW-1:0] count;
   logic valid;
   logic accept;
   logic pop;
   logic close;
   logic [CW-1:0] base;
   logic [CW-1:0] next;
   logic [DATA_WIDTH-1:0] word;
   logic [0:N*DATA_WIDTH-1] vec;
`ifdef CONV_RESULT_GATHER_RELU_EN
   assign word = bus.in_data[DATA_WIDTH-1] ? '0 : bus.in_data;
`else
   assign word = bus.in_data;
`endif
   assign bus.in_ready = !valid || bus.out_ready;
   assign accept = bus.in_valid && bus.in_ready;
   assign pop = valid && bus.out_ready;
   // A completed vector leaving frees every slot, so a same-edge word lands in slot 0.
   assign base = pop ? '0 : count;
   assign next = base + CW'(accept);
   // Flush only matters while collecting and once at least one slot holds data.
   assign close = bus.flush && (state == COLLECT) && (next != '0);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= COLLECT;
         valid <= 1'b0;
         count <= '0;
         for (int k = 0; k < N; k++) slot[k] <= '0;
      end else begin
         for (int k = 0; k < N; k++)
            if (accept && base == CW'(k)) slot[k] <= word;
            else if (close && CW'(k) >= next) slot[k] <= '0;
         if (close || next == CW'(N)) begin
            state <= FULL;
            valid <= 1'b1;
            count <= CW'(N);
         end else begin
            state <= COLLECT;
            valid <= 1'b0;
            count <= next;
         end
      end
   end
   always_comb begin
      vec = '0;
      for (int k = 0; k < N; k++) vec[DATA_WIDTH*k +: DATA_WIDTH] = slot[k];
   end
   assign bus.out_vector = vec;
   assign bus.out_valid = valid;
   assign bus.fill_count = count;
endmodule

// File: doc/conv_result_gather.md
Name: conv_result_gather

Overview:
- Deserializer at the output side of the convolution datapath.
- Accepts a stream of scalar convolution results, one word per handshake, from conv/PE units.
- Packs N consecutive results into one parallel output-row vector in the codebase's flattened [0:N*DATA_WIDTH-1] layout.
- Presents the vector to the downstream layer with a valid/ready handshake. It is the inverse of the serializing feeder in front of each processing element.

Parameters:
- DATA_WIDTH, 32, width of one result word (IEEE-754 single).
- N, 4, number of results packed per output vector; N >= 2.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  DATA_WIDTH  result word.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- flush  input  1  close a partially filled vector, zero-padding the remaining slots.
- out_vector  output  [0:N*DATA_WIDTH-1]  packed results; element k at out_vector[DATA_WIDTH*k +: DATA_WIDTH].
- out_valid  output  1  out_vector complete.
- out_ready  input  1  downstream accepts out_vector.
- fill_count  output  clog2(N+1)  number of slots currently filled.

Behaviour:
- Reset (reset == 0, async): out_vector = 0, out_valid = 0, fill_count = 0, state = COLLECT. in_ready is 1 immediately after reset release. Reset mid-vector discards partial data.
- States:
  - COLLECT: fill_count < N.
  - FULL: fill_count == N, out_valid = 1.
- in_ready = !out_valid || out_ready (combinational).
- Accept: in_valid && in_ready at a rising edge. in_data is written to slot fill_count and fill_count increments. All other slots hold their value.
- Latency: out_valid rises on the same edge that accepts the N-th word, so it is visible 1 cycle after that word is presented.
- Output handshake: when out_valid && out_ready at an edge:
  - fill_count becomes 0, or 1 if an input word is accepted on the same edge. That word goes to slot 0.
  - Slots other than those written are not cleared.
  - out_valid falls unless the new fill_count == N (impossible for N >= 2).
- FULL && !out_ready: in_ready = 0, out_vector and out_valid are held stable. No data is lost or overwritten.
- Flush:
  - Sampled only in COLLECT with fill_count > 0 (after applying any same-edge accept). All remaining slots are written to 0, fill_count becomes N and out_valid becomes 1 on that edge.
  - Flush with in_valid on the same edge: the word is captured first, then the remaining slots are zeroed.
  - Flush with fill_count == 0 and no accept is ignored.
  - Flush in FULL is ignored.
- fill_count wraps only through the output handshake and never exceeds N.
- No arithmetic is performed on data; words are passed bit-exact.

Optional Feature:
- Macro CONV_RESULT_GATHER_RELU_EN.
- Defined: on accept, a word with bit DATA_WIDTH-1 = 1 (negative float, including -0) is stored as all zeros; other words are stored unchanged. This adds no extra latency.
- Undefined: words are stored bit-exact, and no ReLU logic is synthesized.

Test Plan:
- N=4, out_ready=1: stream 0x3F800000, 0x40000000, 0x40400000, 0x40800000 on consecutive cycles -> out_valid 1 cycle after the 4th word; out_vector = {3F800000,40000000,40400000,40800000}; fill_count 1,2,3,4,0.
- Backpressure: fill 4 words with out_ready=0 for 5 cycles while in_valid stays high with 0x41000000 -> in_ready=0, vector held, out_valid held. Raise out_ready -> 0x41000000 is captured into slot 0 on the same edge and fill_count=1.
- Flush: 2 words 0x3F800000, 0xBF800000, then flush=1 -> out_vector = {3F800000,BF800000,0,0}, out_valid=1. Flush at fill_count 0 -> no response.
- Flush on the same edge as the 3rd word 0x40A00000 -> slot 2 = 40A00000, slot 3 = 0.
- Reset asserted after 3 words -> out_valid=0 and fill_count=0 immediately (asynchronously). The next 4 words form a clean vector.
- With CONV_RESULT_GATHER_RELU_EN: words 0xC0000000, 0x80000000, 0x3F800000, 0x00000001 -> out_vector = {0,0,3F800000,00000001}. Without the macro, the vector matches the inputs bit-exact.
